// File: rtl/uart_cmd_pkg.sv
// ----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared types for the UART command parser: FSM state encoding, error cause
// codes reported on err_code, and the default frame start marker.
// ----------------------------------------------------------------------------
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        OPCODE,
        LENGTH,
        PAYLOAD,
        CHECK,
        HOLD
    } state_t;

    typedef enum logic [1:0] {
        ERR_TIMEOUT = 2'b00,
        ERR_LEN     = 2'b01,
        ERR_CHK     = 2'b10,
        ERR_OVERRUN = 2'b11
    } err_code_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// ----------------------------------------------------------------------------
// uart_cmd_parser_if
// Valid/ready command bus between the parser (master) and the MRAM
// data-collection controller (slave).
//   cmd_valid   : command available
//   cmd_ready   : consumer accepts the command
//   cmd_opcode  : OPCODE of the held frame
//   cmd_len     : LEN of the held frame
//   cmd_payload : payload, byte 0 in bits [7:0], unused bytes zero
// ----------------------------------------------------------------------------
interface uart_cmd_parser_if #(
    parameter int MAX_PAYLOAD = 8
);
    localparam int LEN_W = $clog2(MAX_PAYLOAD + 1);

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [7:0]               cmd_opcode;
    logic [LEN_W-1:0]         cmd_len;
    logic [MAX_PAYLOAD*8-1:0] cmd_payload;

    modport master (output cmd_valid, cmd_opcode, cmd_len, cmd_payload,
                    input  cmd_ready);
    modport slave  (input  cmd_valid, cmd_opcode, cmd_len, cmd_payload,
                    output cmd_ready);
endinterface

// File: rtl/uart_rx_strobe.sv
// ----------------------------------------------------------------------------
// uart_rx_strobe
// Turns the UART receiver's rx_valid level into a one-cycle strobe on each
// rising edge, so a level held high across bytes is consumed only once.
//   uart_clock, uart_reset : clock, async active-low reset
//   rx_data, rx_valid      : byte and level from the UART receiver
//   strobe                 : high for the single cycle of an rx_valid rise
//   rx_byte                : byte to use in the strobe cycle
// ----------------------------------------------------------------------------
module uart_rx_strobe (
    input  logic       uart_clock,
    input  logic       uart_reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       strobe,
    output logic [7:0] rx_byte
);
    logic rx_valid_q;

    always_ff @(posedge uart_clock or negedge uart_reset) begin
        if (!uart_reset) rx_valid_q <= 1'b0;
        else             rx_valid_q <= rx_valid;
    end

    assign strobe  = rx_valid & ~rx_valid_q;
    assign rx_byte = rx_data;
endmodule

// File: rtl/uart_cmd_parser.sv
// ----------------------------------------------------------------------------
// uart_cmd_parser
// Assembles UART bytes into frames SYNC, OPCODE, LEN, payload[LEN], CHK
// (CHK = XOR of OPCODE, LEN and payload) and presents good frames on a
// valid/ready command bus. Bad frames produce a one-cycle error pulse.
//   uart_clock, uart_reset : clock, async active-low reset
//   rx_data, rx_valid      : UART receiver byte and level
//   cmd                    : command bus (master side)
//   err_strobe, err_code   : error pulse and cause (00 timeout, 01 length,
//                            10 checksum, 11 overrun)
//   frame_count            : accepted commands, wraps at 16 bits
// Build option: define UART_CMD_TIMEOUT_EN to abort a frame after
// TIMEOUT_CYCLES without a byte; otherwise the parser waits indefinitely.
//
// state   | meaning
// IDLE    | hunting for SYNC_BYTE, other bytes ignored
// OPCODE  | next byte is the opcode
// LENGTH  | next byte is LEN, checked against MAX_PAYLOAD
// PAYLOAD | collecting LEN payload bytes
// CHECK   | next byte is the checksum
// HOLD    | command presented, waiting for cmd_ready
// ----------------------------------------------------------------------------
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int          MAX_PAYLOAD    = 8,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd500000
) (
    input  logic              uart_clock,
    input  logic              uart_reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    uart_cmd_parser_if.master cmd,
    output logic              err_strobe,
    output logic [1:0]        err_code,
    output logic [15:0]       frame_count
);
    localparam int LEN_W = $clog2(MAX_PAYLOAD + 1);

    logic       strobe;
    logic [7:0] rx_byte;

    uart_rx_strobe u_strobe (
        .uart_clock (uart_clock),
        .uart_reset (uart_reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .strobe     (strobe),
        .rx_byte    (rx_byte)
    );

    state_t                   state, state_d;
    logic [7:0]               acc, acc_d;
    logic [7:0]               opcode_buf, opcode_d;
    logic [LEN_W-1:0]         len_buf, len_d;
    logic [LEN_W-1:0]         idx, idx_d;
    logic [MAX_PAYLOAD*8-1:0] payload_buf, payload_d;
    logic [7:0]               cmd_opcode_q;
    logic [LEN_W-1:0]         cmd_len_q;
    logic [MAX_PAYLOAD*8-1:0] cmd_payload_q;
    logic                     commit, handshake, err_d;
    err_code_t                code_d;

`ifdef UART_CMD_TIMEOUT_EN
    logic [23:0] tmo_cnt;
    logic        tmo_active, tmo_hit;

    assign tmo_active = state inside {OPCODE, LENGTH, PAYLOAD, CHECK};
    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign tmo_hit    = tmo_active && !strobe && (tmo_cnt == TIMEOUT_CYCLES - 24'd1);

    always_ff @(posedge uart_clock or negedge uart_reset) begin
        if (!uart_reset)                          tmo_cnt <= '0;
        else if (!tmo_active || strobe || tmo_hit) tmo_cnt <= '0;
        else                                      tmo_cnt <= tmo_cnt + 24'd1;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d   = state;
        acc_d     = acc;
        opcode_d  = opcode_buf;
        len_d     = len_buf;
        idx_d     = idx;
        payload_d = payload_buf;
        commit    = 1'b0;
        handshake = 1'b0;
        err_d     = 1'b0;
        code_d    = ERR_TIMEOUT;

        case (state)
            IDLE: begin
                if (strobe && rx_byte == SYNC_BYTE) begin
                    payload_d = '0;
                    acc_d     = '0;
                    state_d   = OPCODE;
                end
            end
            OPCODE: begin
                if (strobe) begin
                    opcode_d = rx_byte;
                    acc_d    = rx_byte;
                    state_d  = LENGTH;
                end
            end
            LENGTH: begin
                if (strobe) begin
                    if (rx_byte > 8'(MAX_PAYLOAD)) begin
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                        state_d = IDLE;
                    end else if (rx_byte == 8'd0) begin
                        len_d   = '0;
                        state_d = CHECK;
                    end else begin
                        len_d   = rx_byte[LEN_W-1:0];
                        acc_d   = acc ^ rx_byte;
                        idx_d   = '0;
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (strobe) begin
                    payload_d[{idx, 3'b000} +: 8] = rx_byte;
                    acc_d = acc ^ rx_byte;
                    idx_d = idx + 1'b1;
                    if (idx == len_buf - 1'b1) state_d = CHECK;
                end
            end
            CHECK: begin
                if (strobe) begin
                    if (rx_byte == acc) begin
                        commit  = 1'b1;
                        state_d = HOLD;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_CHK;
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                handshake = cmd.cmd_ready;
                if (handshake) begin
                    // A byte coinciding with the handshake is treated as an IDLE byte.
                    if (strobe && rx_byte == SYNC_BYTE) begin
                        payload_d = '0;
                        acc_d     = '0;
                        state_d   = OPCODE;
                    end else begin
                        state_d   = IDLE;
                    end
                end else if (strobe) begin
                    err_d  = 1'b1;
                    code_d = ERR_OVERRUN;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef UART_CMD_TIMEOUT_EN
        if (tmo_hit) begin
            state_d = IDLE;
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
        end
`endif
    end

    always_ff @(posedge uart_clock or negedge uart_reset) begin
        if (!uart_reset) begin
            state         <= IDLE;
            acc           <= '0;
            opcode_buf    <= '0;
            len_buf       <= '0;
            idx           <= '0;
            payload_buf   <= '0;
            cmd_opcode_q  <= '0;
            cmd_len_q     <= '0;
            cmd_payload_q <= '0;
            err_strobe    <= 1'b0;
            err_code      <= 2'b00;
            frame_count   <= '0;
        end else begin
            state       <= state_d;
            acc         <= acc_d;
            opcode_buf  <= opcode_d;
            len_buf     <= len_d;
            idx         <= idx_d;
            payload_buf <= payload_d;
            err_strobe  <= err_d;
            if (err_d) err_code <= code_d;
            // Outputs only move on a good checksum, so bad frames leave them intact.
            if (commit) begin
                cmd_opcode_q  <= opcode_buf;
                cmd_len_q     <= len_buf;
                cmd_payload_q <= payload_buf;
            end
            if (handshake) frame_count <= frame_count + 16'd1;
        end
    end

    assign cmd.cmd_valid   = (state == HOLD);
    assign cmd.cmd_opcode  = cmd_opcode_q;
    assign cmd.cmd_len     = cmd_len_q;
    assign cmd.cmd_payload = cmd_payload_q;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// ----------------------------------------------------------------------------
// tb_uart_cmd_parser
// Self-checking bench for uart_cmd_parser: a frame-level reference model is
// compared against the DUT every cycle, plus directed frames with literal
// expectations and a randomized frame stream with random back-pressure.
// ----------------------------------------------------------------------------
module tb_uart_cmd_parser;
    localparam int MAXP = 8;

    logic        uart_clock = 1'b0;
    logic        uart_reset = 1'b0;
    logic [7:0]  rx_data    = 8'h00;
    logic        rx_valid   = 1'b0;
    logic        err_strobe;
    logic [1:0]  err_code;
    logic [15:0] frame_count;

    uart_cmd_parser_if #(.MAX_PAYLOAD(MAXP)) cmd_bus ();

    uart_cmd_parser #(.MAX_PAYLOAD(MAXP)) dut (
        .uart_clock  (uart_clock),
        .uart_reset  (uart_reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .cmd         (cmd_bus),
        .err_strobe  (err_strobe),
        .err_code    (err_code),
        .frame_count (frame_count)
    );

    always #5 uart_clock = ~uart_clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    bit          m_prev = 1'b0;
    bit          m_hold = 1'b0;
    bit          m_inframe = 1'b0;
    logic [7:0]  m_buf[$];
    logic [7:0]  m_op = '0;
    logic [3:0]  m_len = '0;
    logic [63:0] m_pay = '0;
    logic [15:0] m_cnt = '0;
    bit          m_err = 1'b0;
    logic [1:0]  m_code = '0;

    initial begin
        bit         stb;
        logic [7:0] x;
        forever begin
            @(posedge uart_clock or negedge uart_reset);
            if (!uart_reset) begin
                m_prev = 0; m_hold = 0; m_inframe = 0; m_buf.delete();
                m_op = '0; m_len = '0; m_pay = '0; m_cnt = '0; m_err = 0; m_code = '0;
            end else begin
                stb    = rx_valid && !m_prev;
                m_prev = rx_valid;
                m_err  = 0;
                if (m_hold) begin
                    if (cmd_bus.cmd_ready) begin
                        m_hold = 0;
                        m_cnt  = m_cnt + 16'd1;
                        if (stb && rx_data == 8'hA5) begin m_inframe = 1; m_buf.delete(); end
                    end else if (stb) begin
                        m_err = 1; m_code = 2'b11;
                    end
                end else if (stb) begin
                    if (!m_inframe) begin
                        if (rx_data == 8'hA5) begin m_inframe = 1; m_buf.delete(); end
                    end else begin
                        m_buf.push_back(rx_data);
                        if (m_buf.size() == 2 && m_buf[1] > MAXP) begin
                            m_err = 1; m_code = 2'b01; m_inframe = 0;
                        end else if (m_buf.size() >= 2 && m_buf.size() == int'(m_buf[1]) + 3) begin
                            x = 8'h00;
                            for (int i = 0; i < m_buf.size() - 1; i++) x = x ^ m_buf[i];
                            if (x == m_buf[m_buf.size() - 1]) begin
                                m_hold = 1;
                                m_op   = m_buf[0];
                                m_len  = m_buf[1][3:0];
                                m_pay  = '0;
                                for (int i = 0; i < int'(m_buf[1]); i++) m_pay[i*8 +: 8] = m_buf[2 + i];
                            end else begin
                                m_err = 1; m_code = 2'b10;
                            end
                            m_inframe = 0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare + error monitor ----------------
    int         err_seen = 0;
    logic [1:0] last_err = '0;

    initial forever begin
        @(negedge uart_clock);
        if (err_strobe === 1'b1) begin err_seen++; last_err = err_code; end
        check("cmd_valid",   cmd_bus.cmd_valid,   m_hold);
        check("err_strobe",  err_strobe,          m_err);
        if (m_err) check("err_code", err_code, m_code);
        check("frame_count", frame_count,         m_cnt);
        check("cmd_opcode",  cmd_bus.cmd_opcode,  m_op);
        check("cmd_len",     cmd_bus.cmd_len,     m_len);
        check("cmd_payload", cmd_bus.cmd_payload, m_pay);
    end

    // ---------------- stimulus ----------------
    int ready_mode = 2;   // 0: always ready, 1: random, 2: held low
    int hold_max   = 0;

    initial begin
        cmd_bus.cmd_ready = 1'b0;
        forever begin
            @(posedge uart_clock); #1;
            case (ready_mode)
                0:       cmd_bus.cmd_ready = 1'b1;
                1:       cmd_bus.cmd_ready = 1'($urandom_range(0, 1));
                default: cmd_bus.cmd_ready = 1'b0;
            endcase
        end
    end

    task automatic tick();
        @(posedge uart_clock); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        repeat ($urandom_range(0, hold_max)) begin
            rx_data = 8'($urandom);
            tick();
        end
        rx_valid = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
    endtask

    // Sends n bytes of 'bytes', most significant byte first.
    task automatic send_str(input logic [63:0] bytes, input int n);
        for (int i = n - 1; i >= 0; i--) send_byte(bytes[i*8 +: 8]);
    endtask

    initial begin
        int e0;
        logic [7:0] q[$];
        logic [7:0] op, b, x;
        int n, kind;

        repeat (3) tick();
        uart_reset = 1'b1;
        tick();
        check("reset cmd_valid",   cmd_bus.cmd_valid, 0);
        check("reset frame_count", frame_count, 0);
        check("reset err_strobe",  err_strobe, 0);

        // good frame, consumer stalled so the command can be inspected
        send_str(48'hA5_10_02_55_AA_ED, 6);
        check("good valid",   cmd_bus.cmd_valid, 1);
        check("good opcode",  cmd_bus.cmd_opcode, 8'h10);
        check("good len",     cmd_bus.cmd_len, 2);
        check("good payload", cmd_bus.cmd_payload, 64'h0000_0000_0000_AA55);
        ready_mode = 0;
        repeat (3) tick();
        check("good count",       frame_count, 1);
        check("good valid drop",  cmd_bus.cmd_valid, 0);
        check("good opcode kept", cmd_bus.cmd_opcode, 8'h10);

        // garbage then zero-length frame
        e0 = err_seen;
        send_str(48'h00_FF_A5_3C_00_3C, 6);
        repeat (2) tick();
        check("zero len",     cmd_bus.cmd_len, 0);
        check("zero payload", cmd_bus.cmd_payload, 0);
        check("zero opcode",  cmd_bus.cmd_opcode, 8'h3C);
        check("zero count",   frame_count, 2);
        check("garbage no err", err_seen, e0);

        // bad length
        e0 = err_seen;
        send_str(24'hA5_10_09, 3);
        check("badlen errs", err_seen, e0 + 1);
        check("badlen code", last_err, 2'b01);

        // bad checksum
        e0 = err_seen;
        send_str(48'hA5_10_02_55_AA_EE, 6);
        check("badchk errs",  err_seen, e0 + 1);
        check("badchk code",  last_err, 2'b10);
        check("badchk count", frame_count, 2);

        // back-pressure and overrun
        ready_mode = 2;
        repeat (2) tick();
        send_str(40'hA5_22_01_5A_79, 5);
        check("hold valid", cmd_bus.cmd_valid, 1);
        e0 = err_seen;
        send_byte(8'h00);
        check("overrun errs",    err_seen, e0 + 1);
        check("overrun code",    last_err, 2'b11);
        check("overrun valid",   cmd_bus.cmd_valid, 1);
        check("overrun opcode",  cmd_bus.cmd_opcode, 8'h22);
        check("overrun len",     cmd_bus.cmd_len, 1);
        check("overrun payload", cmd_bus.cmd_payload, 64'h5A);
        ready_mode = 0;
        repeat (3) tick();
        check("overrun count", frame_count, 3);

        // rx_valid held high across several cycles per byte
        hold_max = 4;
        send_str(48'hA5_10_02_55_AA_ED, 6);
        hold_max = 0;
        repeat (2) tick();
        check("held count", frame_count, 4);

        // long silence mid-frame: default build must keep waiting
        e0 = err_seen;
        send_str(16'hA5_10, 2);
        repeat (600) tick();
        check("silence no err", err_seen, e0);
        send_str(24'h01_77_66, 3);
        repeat (2) tick();
        check("silence count",   frame_count, 5);
        check("silence payload", cmd_bus.cmd_payload, 64'h77);

        // reset in the middle of a payload
        send_str(40'hA5_10_04_11_22, 5);
        uart_reset = 1'b0;
        #2;
        check("rst valid",   cmd_bus.cmd_valid, 0);
        check("rst count",   frame_count, 0);
        check("rst opcode",  cmd_bus.cmd_opcode, 0);
        check("rst payload", cmd_bus.cmd_payload, 0);
        check("rst err",     err_strobe, 0);
        tick();
        uart_reset = 1'b1;
        tick();
        send_str(32'hA5_3C_00_3C, 4);
        repeat (2) tick();
        check("post rst count", frame_count, 1);

        // randomized frame stream with random back-pressure
        ready_mode = 1;
        hold_max   = 2;
        for (int f = 0; f < 80; f++) begin
            q.delete();
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h00;
                q.push_back(b);
            end
            q.push_back(8'hA5);
            op   = 8'($urandom);
            kind = $urandom_range(0, 9);
            q.push_back(op);
            if (kind == 0) begin
                q.push_back(8'($urandom_range(9, 255)));
            end else begin
                n = $urandom_range(0, MAXP);
                q.push_back(8'(n));
                x = op ^ 8'(n);
                for (int i = 0; i < n; i++) begin
                    b = 8'($urandom);
                    q.push_back(b);
                    x = x ^ b;
                end
                if (kind == 1) x = x ^ (8'h01 << $urandom_range(0, 7));
                q.push_back(x);
            end
            foreach (q[i]) send_byte(q[i]);
        end
        ready_mode = 0;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
